exec_sequencer: RTL and testbench

Run/step/halt controller that sequences the single-cycle core.
- Each instruction retires only on a one-cycle commit strobe. pc_en gates the PC update; wb_en gates the register-file and data-memory writes.
- Supports free-run at a divided pace and single-step on the debounced step button.
- IN instructions stall until the debounced enter button is pressed.
- Owns the halt state and a retired-instruction counter for the board display.

---
 rtl/exec_sequencer_pkg.sv | 13 +
 rtl/exec_sequencer_if.sv | 24 ++
 rtl/exec_sequencer_rise_detect.sv | 12 +
 rtl/exec_sequencer.sv | 55 +++++
 tb/tb_exec_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: state encodings and default sizing shared by the sequencer slice
package seq_pkg;
  typedef enum logic [2:0] {
    SETTLE    = 3'd0,
    FETCH     = 3'd1,
    STEP_WAIT = 3'd2,
    IN_WAIT   = 3'd3,
    COMMIT    = 3'd4,
    HALT      = 3'd5
  } state_t;
  localparam int RUN_DIV_DEF = 4;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: board/core request lines in, retire strobes and status out
interface exec_sequencer_if #(parameter int CNT_W = seq_pkg::CNT_W_DEF);
  logic run_mode;
  logic step_btn;
  logic in_btn;
  logic in_req;
  logic out_req;
  logic hlt;
  logic pc_en;
  logic wb_en;
  logic in_sel;
  logic disp_load;
  logic halted;
  logic [2:0] state_o;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  run_mode, step_btn, in_btn, in_req, out_req, hlt,
    output pc_en, wb_en, in_sel, disp_load, halted, state_o, instr_count
  );
  modport slave (
    output run_mode, step_btn, in_btn, in_req, out_req, hlt,
    input  pc_en, wb_en, in_sel, disp_load, halted, state_o, instr_count
  );
endinterface

// File: rtl/exec_sequencer_rise_detect.sv
// rise_detect: registered rising-edge detector; prev resets high so a held level gives no edge
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk)
    prev <= reset ? 1'b1 : level;
  assign rise = level & ~prev;
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: run/step/halt controller issuing one commit strobe per retired instruction
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  exec_sequencer_if.master bus
);
  localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(RUN_DIV - 1);
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [CNT_W-1:0] count;
  logic is_in, step_rise, in_rise, fetch_go;
  rise_detect u_step (.clk(clk), .reset(reset), .level(bus.step_btn), .rise(step_rise));
  rise_detect u_in (.clk(clk), .reset(reset), .level(bus.in_btn), .rise(in_rise));
  assign fetch_go = state == FETCH && !bus.hlt && !bus.in_req && bus.run_mode;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SETTLE;
      div_cnt <= '0;
      is_in <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      div_cnt <= fetch_go && div_cnt != LAST ? div_cnt + 1'b1 : '0;
      is_in <= state == COMMIT ? 1'b0 : (state == FETCH && !bus.hlt && bus.in_req) ? 1'b1 : is_in;
      count <= count + CNT_W'(state == COMMIT);
    end
  end
  always_comb begin
    state_nx = SETTLE;
    case (state)
      SETTLE:    state_nx = FETCH;
      FETCH:     state_nx = bus.hlt ? HALT : bus.in_req ? IN_WAIT :
                            bus.run_mode ? (div_cnt == LAST ? COMMIT : FETCH) : STEP_WAIT;
      STEP_WAIT: state_nx = step_rise ? COMMIT : bus.run_mode ? FETCH : STEP_WAIT;
      IN_WAIT:   state_nx = in_rise ? COMMIT : IN_WAIT;
      COMMIT:    state_nx = SETTLE;
      HALT:      state_nx = HALT;
      default:   state_nx = SETTLE;
    endcase
  end
  // the display strobe follows the instruction's own out_req while it retires
  assign bus.pc_en = state == COMMIT;
  assign bus.wb_en = state == COMMIT;
  assign bus.disp_load = state == COMMIT && bus.out_req;
  assign bus.in_sel = state == IN_WAIT || (state == COMMIT && is_in);
  assign bus.halted = state == HALT;
  assign bus.state_o = state;
  assign bus.instr_count = count;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed scenarios for the run/step/in/halt sequencer
module tb_exec_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exec_sequencer_if #(.CNT_W(16)) bus ();
  exec_sequencer_if #(.CNT_W(8)) bus2 ();
  exec_sequencer #(.RUN_DIV(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  exec_sequencer #(.RUN_DIV(1), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic clear_inputs;
    bus.run_mode = 1'b0; bus.step_btn = 1'b0; bus.in_btn = 1'b0;
    bus.in_req = 1'b0; bus.out_req = 1'b0; bus.hlt = 1'b0;
  endtask
  task automatic test_reset;
    clear_inputs();
    bus.run_mode = 1'b1;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.pc_en, bus.wb_en, bus.in_sel, bus.disp_load, bus.halted} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=00000", {bus.pc_en, bus.wb_en, bus.in_sel, bus.disp_load, bus.halted});
    end
    checks++;
    if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
    checks++;
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
    reset = 1'b0;
  endtask
  task automatic test_run;
    clear_inputs();
    bus.run_mode = 1'b1;
    do_reset();
    // SETTLE, four FETCH cycles, then COMMIT: pulses land 5, 11, 17 edges after the reset edge
    for (int i = 1; i <= 18; i++) begin
      tick();
      checks++;
      if (bus.pc_en !== (i % 6 == 5) || bus.wb_en !== (i % 6 == 5)) begin
        errors++; $display("FAIL run_pulse cyc=%0d got=%b%b exp=%b", i, bus.pc_en, bus.wb_en, i % 6 == 5);
      end
    end
    checks++;
    if (bus.instr_count !== 16'd3) begin errors++; $display("FAIL run_count got=%0d exp=3", bus.instr_count); end
  endtask
  task automatic test_step;
    int pulses = 0;
    clear_inputs();
    do_reset();
    for (int i = 0; i < 100; i++) begin tick(); pulses += int'(bus.pc_en); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL step_idle got=%0d exp=0", pulses); end
    checks++;
    if (bus.state_o !== 3'd2) begin errors++; $display("FAIL step_wait_state got=%0d exp=2", bus.state_o); end
    bus.step_btn = 1'b1;
    tick();
    checks++;
    if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL step_commit got=%b exp=1", bus.pc_en); end
    pulses = 0;
    for (int i = 0; i < 49; i++) begin tick(); pulses += int'(bus.pc_en); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL step_held got=%0d exp=0", pulses); end
    checks++;
    if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL step_count got=%0d exp=1", bus.instr_count); end
    bus.step_btn = 1'b0;
  endtask
  task automatic test_in_wait;
    int pulses = 0;
    clear_inputs();
    bus.run_mode = 1'b1;
    bus.in_req = 1'b1;
    do_reset();
    tick(); tick();
    checks++;
    if (bus.state_o !== 3'd3 || bus.in_sel !== 1'b1) begin
      errors++; $display("FAIL in_wait_entry got=%0d/%b exp=3/1", bus.state_o, bus.in_sel);
    end
    for (int i = 0; i < 200; i++) begin tick(); pulses += int'(bus.pc_en); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL in_stall got=%0d exp=0", pulses); end
    bus.in_btn = 1'b1;
    tick();
    checks++;
    if (bus.pc_en !== 1'b1 || bus.in_sel !== 1'b1) begin
      errors++; $display("FAIL in_commit got=%b%b exp=11", bus.pc_en, bus.in_sel);
    end
    tick();
    checks++;
    if (bus.in_sel !== 1'b0 || bus.pc_en !== 1'b0) begin
      errors++; $display("FAIL in_after got=%b%b exp=00", bus.in_sel, bus.pc_en);
    end
    checks++;
    if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL in_count got=%0d exp=1", bus.instr_count); end
    clear_inputs();
  endtask
  task automatic test_halt;
    int pulses = 0;
    clear_inputs();
    bus.hlt = 1'b1;
    bus.in_req = 1'b1;
    do_reset();
    tick(); tick();
    checks++;
    if (bus.state_o !== 3'd5 || bus.halted !== 1'b1 || bus.in_sel !== 1'b0) begin
      errors++; $display("FAIL halt_entry got=%0d/%b/%b exp=5/1/0", bus.state_o, bus.halted, bus.in_sel);
    end
    bus.hlt = 1'b0;
    bus.in_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.step_btn = i[1];
      bus.in_btn = i[2];
      bus.run_mode = i[0];
      tick();
      pulses += int'(bus.pc_en | bus.wb_en | bus.disp_load | bus.in_sel);
    end
    checks++;
    if (pulses != 0 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL halt_sticky got=%0d/%b exp=0/1", pulses, bus.halted);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.halted !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL halt_reset got=%b/%0d exp=0/0", bus.halted, bus.state_o);
    end
    reset = 1'b0;
  endtask
  task automatic test_disp;
    int loads = 0;
    clear_inputs();
    bus.run_mode = 1'b1;
    bus.out_req = 1'b1;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick();
      loads += int'(bus.disp_load);
      checks++;
      if (bus.disp_load !== (i % 6 == 5)) begin
        errors++; $display("FAIL disp_run cyc=%0d got=%b exp=%b", i, bus.disp_load, i % 6 == 5);
      end
    end
    checks++;
    if (loads != 2) begin errors++; $display("FAIL disp_total got=%0d exp=2", loads); end
    clear_inputs();
    do_reset();
    tick(); tick();
    bus.out_req = 1'b1;
    loads = 0;
    for (int i = 0; i < 5; i++) begin tick(); loads += int'(bus.disp_load); end
    bus.out_req = 1'b0;
    bus.step_btn = 1'b1;
    tick();
    checks++;
    if (loads != 0 || bus.disp_load !== 1'b0 || bus.pc_en !== 1'b1) begin
      errors++; $display("FAIL disp_step got=%0d/%b/%b exp=0/0/1", loads, bus.disp_load, bus.pc_en);
    end
    clear_inputs();
  endtask
  task automatic test_wrap;
    clear_inputs();
    bus2.run_mode = 1'b1; bus2.step_btn = 1'b0; bus2.in_btn = 1'b0;
    bus2.in_req = 1'b0; bus2.out_req = 1'b0; bus2.hlt = 1'b0;
    do_reset();
    // RUN_DIV=1: commit every 3 cycles, the 256th lands 767 edges after the reset edge
    for (int i = 0; i < 766; i++) tick();
    tick();
    checks++;
    if (bus2.instr_count !== 8'hFF || bus2.pc_en !== 1'b1) begin
      errors++; $display("FAIL wrap_pre got=%h/%b exp=ff/1", bus2.instr_count, bus2.pc_en);
    end
    tick();
    checks++;
    if (bus2.instr_count !== 8'h00) begin errors++; $display("FAIL wrap_post got=%h exp=00", bus2.instr_count); end
  endtask
  task automatic test_reset_in_wait;
    int pulses = 0;
    clear_inputs();
    bus.run_mode = 1'b1;
    bus.in_req = 1'b1;
    do_reset();
    tick(); tick();
    bus.in_btn = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.pc_en, bus.wb_en, bus.in_sel, bus.disp_load, bus.halted} !== 5'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL mid_reset got=%b/%0d exp=00000/0",
        {bus.pc_en, bus.wb_en, bus.in_sel, bus.disp_load, bus.halted}, bus.state_o);
    end
    checks++;
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", bus.instr_count); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); pulses += int'(bus.pc_en); end
    checks++;
    if (pulses != 0 || bus.state_o !== 3'd3) begin
      errors++; $display("FAIL held_btn got=%0d/%0d exp=0/3", pulses, bus.state_o);
    end
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    bus2.run_mode = 1'b0; bus2.step_btn = 1'b0; bus2.in_btn = 1'b0;
    bus2.in_req = 1'b0; bus2.out_req = 1'b0; bus2.hlt = 1'b0;
    test_reset();
    test_run();
    test_step();
    test_in_wait();
    test_halt();
    test_disp();
    test_wrap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
